// File: rtl/alu_unit_pkg.sv
// Shared opcode encodings, tag/opcode widths and FSM state codes for alu_unit.
package alu_unit_pkg;

  localparam int ROBSIZE      = 4;
  localparam int RS_TYPE_SIZE = 5;

  typedef enum logic [RS_TYPE_SIZE-1:0] {
    ALU_ADD  = 5'd0,
    ALU_SUB  = 5'd1,
    ALU_SLL  = 5'd2,
    ALU_SLT  = 5'd3,
    ALU_SLTU = 5'd4,
    ALU_XOR  = 5'd5,
    ALU_SRL  = 5'd6,
    ALU_SRA  = 5'd7,
    ALU_OR   = 5'd8,
    ALU_AND  = 5'd9,
    BEQ      = 5'd10,
    BNE      = 5'd11,
    BLT      = 5'd12,
    BGE      = 5'd13,
    BLTU     = 5'd14,
    BGEU     = 5'd15,
    MUL      = 5'd16,
    MULH     = 5'd17,
    MULHSU   = 5'd18,
    MULHU    = 5'd19,
    DIV      = 5'd20,
    DIVU     = 5'd21,
    REM      = 5'd22,
    REMU     = 5'd23
  } alu_op_e;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MUL  = 2'd1;
  localparam logic [1:0] ST_DIV  = 2'd2;

  function automatic logic is_mul_op(input alu_op_e op);
    return op inside {MUL, MULH, MULHSU, MULHU};
  endfunction

  function automatic logic is_div_op(input alu_op_e op);
    return op inside {DIV, DIVU, REM, REMU};
  endfunction

endpackage

// File: rtl/alu_divider.sv
// Restoring radix-2 divider: one quotient bit per enabled cycle, signs fixed up
// on the final iteration so quotient/remainder are valid in the cycle done is high.
module alu_divider #(
  parameter int WIDTH     = 32,
  parameter int DIV_ITERS = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clear,
  input  logic             start,
  input  logic             sgn,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             done
);

  localparam int CNT_W = $clog2(DIV_ITERS + 1);

  logic             busy_q, busy_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d, quo_q, quo_d, dvsr_q, dvsr_d;
  logic             neg_q_q, neg_q_d, neg_r_q, neg_r_d, dz_q, dz_d;
  logic [WIDTH:0]   shifted, diff;
  logic [WIDTH-1:0] rem_step, quo_step;

  // NOTE: every signal assigned in an always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    shifted  = {rem_q, quo_q[WIDTH-1]};
    diff     = shifted - {1'b0, dvsr_q};
    rem_step = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
    quo_step = {quo_q[WIDTH-2:0], ~diff[WIDTH]};

    done      = busy_q && (cnt_q == CNT_W'(DIV_ITERS - 1));
    quotient  = dz_q ? '1 : (neg_q_q ? -quo_step : quo_step);
    remainder = neg_r_q ? -rem_step : rem_step;

    busy_d  = busy_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvsr_d  = dvsr_q;
    neg_q_d = neg_q_q;
    neg_r_d = neg_r_q;
    dz_d    = dz_q;

    if (clear) begin
      busy_d = 1'b0;
      cnt_d  = '0;
    end else if (start) begin
      busy_d  = 1'b1;
      cnt_d   = '0;
      rem_d   = '0;
      quo_d   = (sgn && dividend[WIDTH-1]) ? -dividend : dividend;
      dvsr_d  = (sgn && divisor[WIDTH-1])  ? -divisor  : divisor;
      neg_q_d = sgn && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
      neg_r_d = sgn && dividend[WIDTH-1];
      dz_d    = (divisor == '0);
    end else if (busy_q) begin
      rem_d = rem_step;
      quo_d = quo_step;
      cnt_d = cnt_q + CNT_W'(1);
      if (done) begin
        busy_d = 1'b0;
        cnt_d  = '0;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q  <= 1'b0;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvsr_q  <= '0;
      neg_q_q <= 1'b0;
      neg_r_q <= 1'b0;
      dz_q    <= 1'b0;
    end else if (en) begin
      busy_q  <= busy_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvsr_q  <= dvsr_d;
      neg_q_q <= neg_q_d;
      neg_r_q <= neg_r_d;
      dz_q    <= dz_d;
    end
  end

endmodule

// File: rtl/alu_unit.sv
// Integer execution unit with registered, ROB-tagged result bus.
// Build option ALU_MDU_EN adds the pipelined multiplier and iterative divider.
module alu_unit
  import alu_unit_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int DIV_ITERS = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    rdy,
  input  logic                    clear,
  input  logic                    alu_shot,
  input  logic [WIDTH-1:0]        alu_r1,
  input  logic [WIDTH-1:0]        alu_r2,
  input  logic [ROBSIZE-1:0]      alu_rob_id,
  input  logic [RS_TYPE_SIZE-1:0] alu_work_type,
  output logic                    alu_busy,
  output logic                    alu_ready,
  output logic [ROBSIZE-1:0]      alu_out_rob_id,
  output logic [WIDTH-1:0]        alu_value
);

  alu_op_e            op;
  logic               accept, upd;
  logic [4:0]         shamt;
  logic [WIDTH-1:0]   simple_val;
  logic               ready_q, ready_d;
  logic [ROBSIZE-1:0] rob_q, rob_d;
  logic [WIDTH-1:0]   value_q, value_d;

  assign op     = alu_op_e'(alu_work_type);
  assign shamt  = alu_r2[4:0];
  assign accept = alu_shot && !alu_busy && !clear;
  // A flush must land even while the pipeline is stalled.
  assign upd    = rdy || clear;

  always_comb begin
    simple_val = '0;
    case (op)
      ALU_ADD:  simple_val = alu_r1 + alu_r2;
      ALU_SUB:  simple_val = alu_r1 - alu_r2;
      ALU_SLL:  simple_val = alu_r1 << shamt;
      ALU_SLT:  simple_val = WIDTH'($signed(alu_r1) < $signed(alu_r2));
      ALU_SLTU: simple_val = WIDTH'(alu_r1 < alu_r2);
      ALU_XOR:  simple_val = alu_r1 ^ alu_r2;
      ALU_SRL:  simple_val = alu_r1 >> shamt;
      ALU_SRA:  simple_val = $unsigned($signed(alu_r1) >>> shamt);
      ALU_OR:   simple_val = alu_r1 | alu_r2;
      ALU_AND:  simple_val = alu_r1 & alu_r2;
      BEQ:      simple_val = WIDTH'(alu_r1 == alu_r2);
      BNE:      simple_val = WIDTH'(alu_r1 != alu_r2);
      BLT:      simple_val = WIDTH'($signed(alu_r1) < $signed(alu_r2));
      BGE:      simple_val = WIDTH'($signed(alu_r1) >= $signed(alu_r2));
      BLTU:     simple_val = WIDTH'(alu_r1 < alu_r2);
      BGEU:     simple_val = WIDTH'(alu_r1 >= alu_r2);
      default:  simple_val = '0;
    endcase
  end

`ifdef ALU_MDU_EN
  logic [1:0]           state_q, state_d;
  logic signed [2*WIDTH-1:0] mul_a, mul_b;
  logic [2*WIDTH-1:0]   mul_prod, mul_prod_q, mul_prod_d;
  logic                 mul_hi_q, mul_hi_d, rem_sel_q, rem_sel_d;
  logic [ROBSIZE-1:0]   pend_rob_q, pend_rob_d;
  logic                 div_start, div_sgn, div_done;
  logic [WIDTH-1:0]     div_quo, div_rem;

  assign alu_busy = (state_q != ST_IDLE);

  // 33x33 signed product, evaluated on sign/zero-extended 64-bit operands.
  assign mul_a    = (op == MULH || op == MULHSU) ? $signed({{WIDTH{alu_r1[WIDTH-1]}}, alu_r1})
                                                 : $signed({{WIDTH{1'b0}}, alu_r1});
  assign mul_b    = (op == MULH) ? $signed({{WIDTH{alu_r2[WIDTH-1]}}, alu_r2})
                                 : $signed({{WIDTH{1'b0}}, alu_r2});
  assign mul_prod = $unsigned(mul_a * mul_b);

  assign div_start = accept && is_div_op(op);
  assign div_sgn   = (op == DIV) || (op == REM);

  alu_divider #(.WIDTH(WIDTH), .DIV_ITERS(DIV_ITERS)) u_div (
    .clk       (clk),
    .rst_n     (rst),
    .en        (upd),
    .clear     (clear),
    .start     (div_start),
    .sgn       (div_sgn),
    .dividend  (alu_r1),
    .divisor   (alu_r2),
    .quotient  (div_quo),
    .remainder (div_rem),
    .done      (div_done)
  );

  always_comb begin
    state_d    = state_q;
    mul_prod_d = mul_prod_q;
    mul_hi_d   = mul_hi_q;
    rem_sel_d  = rem_sel_q;
    pend_rob_d = pend_rob_q;
    ready_d    = 1'b0;
    rob_d      = rob_q;
    value_d    = value_q;
    if (clear) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: if (accept) begin
          if (is_mul_op(op)) begin
            state_d    = ST_MUL;
            mul_prod_d = mul_prod;
            mul_hi_d   = (op != MUL);
            pend_rob_d = alu_rob_id;
          end else if (is_div_op(op)) begin
            state_d    = ST_DIV;
            rem_sel_d  = (op == REM) || (op == REMU);
            pend_rob_d = alu_rob_id;
          end else begin
            ready_d = 1'b1;
            rob_d   = alu_rob_id;
            value_d = simple_val;
          end
        end
        ST_MUL: begin
          state_d = ST_IDLE;
          ready_d = 1'b1;
          rob_d   = pend_rob_q;
          value_d = mul_hi_q ? mul_prod_q[2*WIDTH-1:WIDTH] : mul_prod_q[WIDTH-1:0];
        end
        ST_DIV: if (div_done) begin
          state_d = ST_IDLE;
          ready_d = 1'b1;
          rob_d   = pend_rob_q;
          value_d = rem_sel_q ? div_rem : div_quo;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      mul_prod_q <= '0;
      mul_hi_q   <= 1'b0;
      rem_sel_q  <= 1'b0;
      pend_rob_q <= '0;
    end else if (upd) begin
      state_q    <= state_d;
      mul_prod_q <= mul_prod_d;
      mul_hi_q   <= mul_hi_d;
      rem_sel_q  <= rem_sel_d;
      pend_rob_q <= pend_rob_d;
    end
  end
`else
  assign alu_busy = 1'b0;

  // MDU opcodes still retire in one cycle; simple_val is zero for them.
  always_comb begin
    ready_d = 1'b0;
    rob_d   = rob_q;
    value_d = value_q;
    if (accept) begin
      ready_d = 1'b1;
      rob_d   = alu_rob_id;
      value_d = simple_val;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ready_q <= 1'b0;
      rob_q   <= '0;
      value_q <= '0;
    end else if (upd) begin
      ready_q <= ready_d;
      rob_q   <= rob_d;
      value_q <= value_d;
    end
  end

  assign alu_ready      = ready_q;
  assign alu_out_rob_id = rob_q;
  assign alu_value      = value_q;

endmodule

// File: tb/tb_alu_unit.sv
// Directed self-checking bench for alu_unit; MDU vectors apply when ALU_MDU_EN is defined.
module tb_alu_unit;
  import alu_unit_pkg::*;

  logic                    clk = 1'b0;
  logic                    rst, rdy, clear, alu_shot;
  logic [31:0]             alu_r1, alu_r2;
  logic [ROBSIZE-1:0]      alu_rob_id;
  logic [RS_TYPE_SIZE-1:0] alu_work_type;
  logic                    alu_busy, alu_ready;
  logic [ROBSIZE-1:0]      alu_out_rob_id;
  logic [31:0]             alu_value;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  alu_unit dut (
    .clk            (clk),
    .rst            (rst),
    .rdy            (rdy),
    .clear          (clear),
    .alu_shot       (alu_shot),
    .alu_r1         (alu_r1),
    .alu_r2         (alu_r2),
    .alu_rob_id     (alu_rob_id),
    .alu_work_type  (alu_work_type),
    .alu_busy       (alu_busy),
    .alu_ready      (alu_ready),
    .alu_out_rob_id (alu_out_rob_id),
    .alu_value      (alu_value)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input alu_op_e op, input logic [31:0] a, input logic [31:0] b,
                       input logic [ROBSIZE-1:0] id);
    alu_shot      = 1'b1;
    alu_work_type = op;
    alu_r1        = a;
    alu_r2        = b;
    alu_rob_id    = id;
  endtask

  task automatic single(input string tag, input alu_op_e op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp);
    issue(op, a, b, 4'd7);
    tick();
    alu_shot = 1'b0;
    check({tag, "_rdy"}, 32'(alu_ready), 32'd1);
    check({tag, "_val"}, alu_value, exp);
  endtask

`ifdef ALU_MDU_EN
  task automatic mul_run(input string tag, input alu_op_e op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp);
    issue(op, a, b, 4'd5);
    tick();
    alu_shot = 1'b0;
    check({tag, "_busy1"}, 32'(alu_busy), 32'd1);
    check({tag, "_rdy1"}, 32'(alu_ready), 32'd0);
    tick();
    check({tag, "_rdy2"}, 32'(alu_ready), 32'd1);
    check({tag, "_val"}, alu_value, exp);
    check({tag, "_id"}, 32'(alu_out_rob_id), 32'd5);
    check({tag, "_busy2"}, 32'(alu_busy), 32'd0);
  endtask

  task automatic div_run(input string tag, input alu_op_e op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp,
                         input int stall_at, input int exp_lat);
    int cyc;
    issue(op, a, b, 4'd12);
    tick();
    alu_shot = 1'b0;
    cyc = 1;
    check({tag, "_busy_start"}, 32'(alu_busy), 32'd1);
    while (!alu_ready && cyc < 100) begin
      if (cyc == stall_at) begin
        rdy = 1'b0;
        repeat (5) tick();
        cyc += 5;
        rdy = 1'b1;
      end else begin
        tick();
        cyc++;
      end
    end
    check({tag, "_latency"}, 32'(cyc), 32'(exp_lat));
    check({tag, "_val"}, alu_value, exp);
    check({tag, "_id"}, 32'(alu_out_rob_id), 32'd12);
    check({tag, "_busy_end"}, 32'(alu_busy), 32'd0);
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; rdy = 1'b1; clear = 1'b0; alu_shot = 1'b0;
    alu_r1 = '0; alu_r2 = '0; alu_rob_id = '0; alu_work_type = '0;
    repeat (2) tick();
    check("rst_ready", 32'(alu_ready), 32'd0);
    check("rst_id", 32'(alu_out_rob_id), 32'd0);
    check("rst_value", alu_value, 32'd0);
    check("rst_busy", 32'(alu_busy), 32'd0);
    rst = 1'b1;
    tick();

    // Wrapping add, one-cycle pulse.
    issue(ALU_ADD, 32'hFFFF_FFFF, 32'd1, 4'd3);
    tick();
    alu_shot = 1'b0;
    check("add_rdy", 32'(alu_ready), 32'd1);
    check("add_val", alu_value, 32'd0);
    check("add_id", 32'(alu_out_rob_id), 32'd3);
    tick();
    check("add_rdy_drop", 32'(alu_ready), 32'd0);

    single("sub",  ALU_SUB,  32'd5,         32'd7,         32'hFFFF_FFFE);
    single("sll",  ALU_SLL,  32'd1,         32'h21,        32'd2);
    single("slt",  ALU_SLT,  32'hFFFF_FFFF, 32'd1,         32'd1);
    single("sltu", ALU_SLTU, 32'hFFFF_FFFF, 32'd1,         32'd0);
    single("xor",  ALU_XOR,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0);
    single("srl",  ALU_SRL,  32'h8000_0000, 32'd4,         32'h0800_0000);
    single("sra",  ALU_SRA,  32'h8000_0000, 32'h24,        32'hF800_0000);
    single("or",   ALU_OR,   32'h0F0F_0000, 32'h0000_F0F0, 32'h0F0F_F0F0);
    single("and",  ALU_AND,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000);
    single("beq",  BEQ,      32'd5,         32'd5,         32'd1);
    single("bne",  BNE,      32'd5,         32'd5,         32'd0);
    single("blt",  BLT,      32'hFFFF_FFFF, 32'd1,         32'd1);
    single("bge",  BGE,      32'hFFFF_FFFF, 32'd1,         32'd0);
    single("bltu", BLTU,     32'd1,         32'hFFFF_FFFF, 32'd1);
    single("bgeu", BGEU,     32'd1,         32'hFFFF_FFFF, 32'd0);

    // Stall holds the registered result.
    issue(ALU_ADD, 32'd10, 32'd20, 4'd6);
    tick();
    alu_shot = 1'b0;
    rdy = 1'b0;
    repeat (2) tick();
    check("stall_hold_rdy", 32'(alu_ready), 32'd1);
    check("stall_hold_val", alu_value, 32'd30);
    rdy = 1'b1;
    tick();
    check("stall_no_dup", 32'(alu_ready), 32'd0);

    // Flush discards a same-cycle shot.
    issue(ALU_XOR, 32'd1, 32'd2, 4'd1);
    clear = 1'b1;
    tick();
    alu_shot = 1'b0;
    clear = 1'b0;
    check("clear_shot_dropped", 32'(alu_ready), 32'd0);

`ifdef ALU_MDU_EN
    mul_run("mulh", MULH, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
    issue(ALU_ADD, 32'd2, 32'd3, 4'd6);
    tick();
    alu_shot = 1'b0;
    check("b2b_add_rdy", 32'(alu_ready), 32'd1);
    check("b2b_add_val", alu_value, 32'd5);
    check("b2b_add_id", 32'(alu_out_rob_id), 32'd6);
    mul_run("mulhu",  MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    mul_run("mulhsu", MULHSU, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF);
    mul_run("mul",    MUL,    32'd7,         32'd6,         32'd42);

    div_run("div_neg",  DIV,  32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 0, 33);
    div_run("rem_neg",  REM,  32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 0, 33);
    div_run("divu_z",   DIVU, 32'd5,         32'd0,         32'hFFFF_FFFF, 0, 33);
    div_run("div_z",    DIV,  32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFFF, 0, 33);
    div_run("rem_z",    REM,  32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 0, 33);
    div_run("div_ovf",  DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0, 33);
    div_run("rem_ovf",  REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         0, 33);
    div_run("remu",     REMU, 32'd100,       32'd7,         32'd2,         0, 33);
    div_run("divu_stl", DIVU, 32'd100,       32'd7,         32'd14,        10, 38);

    // Flush mid-divide.
    begin
      bit seen;
      issue(DIV, 32'd1000, 32'd3, 4'd11);
      tick();
      alu_shot = 1'b0;
      repeat (9) tick();
      clear = 1'b1;
      tick();
      clear = 1'b0;
      check("flush_busy", 32'(alu_busy), 32'd0);
      seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
        if (alu_ready && alu_out_rob_id == 4'd11) seen = 1'b1;
        tick();
      end
      check("flush_no_result", 32'(seen), 32'd0);
    end

    // Shot while busy is ignored.
    begin
      int cyc;
      issue(DIVU, 32'd100, 32'd7, 4'd2);
      tick();
      issue(ALU_ADD, 32'd1, 32'd1, 4'd9);
      tick();
      alu_shot = 1'b0;
      cyc = 2;
      while (!alu_ready && cyc < 100) begin
        tick();
        cyc++;
      end
      check("viol_latency", 32'(cyc), 32'd33);
      check("viol_id", 32'(alu_out_rob_id), 32'd2);
      check("viol_val", alu_value, 32'd14);
    end

    // Asynchronous reset mid-divide.
    issue(DIVU, 32'd100, 32'd7, 4'd4);
    tick();
    alu_shot = 1'b0;
    repeat (5) tick();
    rst = 1'b0;
    #1;
    check("rst_mid_busy", 32'(alu_busy), 32'd0);
    check("rst_mid_value", alu_value, 32'd0);
    check("rst_mid_id", 32'(alu_out_rob_id), 32'd0);
    rst = 1'b1;
    tick();
    tick();
    check("rst_mid_no_result", 32'(alu_ready), 32'd0);
`else
    check("nomdu_busy_pre", 32'(alu_busy), 32'd0);
    issue(MUL, 32'd7, 32'd6, 4'd4);
    tick();
    alu_shot = 1'b0;
    check("nomdu_mul_rdy", 32'(alu_ready), 32'd1);
    check("nomdu_mul_val", alu_value, 32'd0);
    check("nomdu_mul_id", 32'(alu_out_rob_id), 32'd4);
    check("nomdu_mul_busy", 32'(alu_busy), 32'd0);
    issue(DIV, 32'd100, 32'd7, 4'd8);
    tick();
    alu_shot = 1'b0;
    check("nomdu_div_rdy", 32'(alu_ready), 32'd1);
    check("nomdu_div_val", alu_value, 32'd0);
    check("nomdu_div_id", 32'(alu_out_rob_id), 32'd8);
`endif

    single("post_add", ALU_ADD, 32'd40, 32'd2, 32'd42);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
